check_node_serial: RTL

CHECK_NODE_SERIAL -- requirements
Module: check_node_serial

---
 rtl/check_node_serial.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/check_node_serial.sv
// check_node_serial
//   Serial min-sum check node for an LDPC decoder. Variable-to-check
//   messages for one check arrive one edge per handshake. The node keeps the
//   two smallest magnitudes, the position of the smallest and the running
//   sign product. It then streams one check-to-variable message per edge,
//   using offset min-sum: every magnitude is reduced by the offset and
//   clamped at zero.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   offset       : unsigned min-sum offset, latched on the first input of a check
//   in_valid/in_ready/in_msg/in_last    : input message stream (signed)
//   out_valid/out_ready/out_msg/out_last: output message stream (signed)
//   deg_err      : sticky flag, set when a check reaches MAX_DEG edges without in_last
module check_node_serial #(
   parameter int N_FP    = 8,
   parameter int MAX_DEG = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_FP-2:0]        offset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [N_FP-1:0] in_msg,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [N_FP-1:0] out_msg,
   output logic                   out_last,
   output logic                   deg_err
);

   localparam int CW = $clog2(MAX_DEG + 1);
   localparam int IW = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;
   localparam int MW = N_FP - 1;
   localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t             state_q, state_d;
   logic [MAX_DEG-1:0] s_q;
   logic [CW-1:0]      count_q;
   logic [IW-1:0]      j_q, idx1_q;
   logic [MW-1:0]      min1_q, min2_q, off_q;
   logic               p_q;

   logic               in_hs, out_hs, eff_last;
   logic [IW-1:0]      k;
   logic [N_FP-1:0]    abs_v, mag_ext;
   logic [MW-1:0]      mag_in, sel, emit_mag;
   logic               neg;

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == EMIT);
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign k         = count_q[IW-1:0];

   // The MAX_DEG-th edge closes the check even without in_last.
   assign eff_last  = in_last | (count_q == CW'(MAX_DEG - 1));

   // Only -2^(N_FP-1) has the MSB set after negation; it saturates to the
   // largest representable magnitude.
   assign abs_v  = in_msg[N_FP-1] ? N_FP'(-in_msg) : N_FP'(in_msg);
   assign mag_in = abs_v[N_FP-1] ? MAG_MAX : abs_v[MW-1:0];

   // Emit path is decoded purely from state, so there is no combinational
   // path from out_ready. The excluded-edge minimum is min2 for the argmin
   // edge and min1 for every other edge.
   assign sel      = (j_q == idx1_q) ? min2_q : min1_q;
   assign emit_mag = (sel > off_q) ? (sel - off_q) : '0;
   assign neg      = p_q ^ s_q[j_q];
   assign mag_ext  = {1'b0, emit_mag};

   always_comb begin
      out_msg  = '0;
      out_last = 1'b0;
      if (state_q == EMIT) begin
         out_msg  = neg ? -mag_ext : mag_ext;
         out_last = ({{(CW-IW){1'b0}}, j_q} == count_q - CW'(1));
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == COLLECT) begin
         if (in_hs && eff_last) state_d = EMIT;
      end else begin
         if (out_hs && out_last) state_d = COLLECT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= COLLECT;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q     <= '0;
         count_q <= '0;
         j_q     <= '0;
         idx1_q  <= '0;
         min1_q  <= MAG_MAX;
         min2_q  <= MAG_MAX;
         off_q   <= '0;
         p_q     <= 1'b0;
         deg_err <= 1'b0;
      end else if (state_q == COLLECT) begin
         if (in_hs) begin
            s_q[k]  <= in_msg[N_FP-1];
            count_q <= count_q + CW'(1);
            p_q     <= p_q ^ in_msg[N_FP-1];
            if (count_q == '0) off_q <= offset;
            // Strict compares: a tie with min1 never moves idx1.
            if (mag_in < min1_q) begin
               min2_q <= min1_q;
               min1_q <= mag_in;
               idx1_q <= k;
            end else if (mag_in < min2_q) begin
               min2_q <= mag_in;
            end
            if (eff_last) j_q <= '0;
            if (eff_last && !in_last) deg_err <= 1'b1;
         end
      end else if (out_hs) begin
         if (out_last) begin
            count_q <= '0;
            j_q     <= '0;
            idx1_q  <= '0;
            min1_q  <= MAG_MAX;
            min2_q  <= MAG_MAX;
            p_q     <= 1'b0;
         end else begin
            j_q <= j_q + IW'(1);
         end
      end
   end

endmodule
